// File: rtl/rtc_burst_seq.sv
// rtc_burst_seq: moves 1..DEPTH consecutive DS1302 registers between the chip and a local
// byte buffer, one rtc_control transaction per byte. Define RTC_AUTO_WP_EN to wrap write bursts in WP clear/set.
module rtc_burst_seq #(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          ioclr,
  input  logic          go,
  input  logic          dir_rd,
  input  logic          ram_sel,
  input  logic [4:0]    base,
  input  logic [IW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          buf_we,
  input  logic [IW-1:0] buf_wa,
  input  logic [7:0]    buf_wd,
  input  logic [IW-1:0] buf_ra,
  output logic [7:0]    buf_rd,
  output logic [6:0]    ctl_cmd,
  output logic [7:0]    ctl_dout,
  output logic          ctl_start,
  input  logic          ctl_idle,
  input  logic [7:0]    ctl_din
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic          ram_q, ram_d;
  logic [4:0]    base_q, base_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic [6:0]    cmd_q, cmd_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    buf_mem [DEPTH];
  logic [4:0]    addr;
  logic          xfer_end;
  logic          last_xfer;
  logic          cap_we;

`ifdef RTC_AUTO_WP_EN
  typedef enum logic [1:0] {PH_PRE, PH_DATA, PH_POST} phase_t;
  phase_t phase_q, phase_d;
`endif

  // Idle is still high in the start cycle, so the handshake only counts once start has dropped.
  assign addr     = base_q + 5'(idx_q);
  assign xfer_end = (state_q == S_WAIT) && !start_q && ctl_idle;
  assign cap_we   = xfer_end && dir_q && !ioclr;

`ifdef RTC_AUTO_WP_EN
  assign last_xfer = (phase_q == PH_POST) || ((phase_q == PH_DATA) && dir_q && (idx_q == len_q));
`else
  assign last_xfer = (idx_q == len_q);
`endif

  always_ff @(posedge clock) begin
    if (ioclr) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE: if (ctl_idle) state_d = S_WAIT;
      S_WAIT:  if (xfer_end) state_d = S_NEXT;
      S_NEXT:  state_d = last_xfer ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dir_d   = dir_q;
    ram_d   = ram_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = 1'b0;
    cmd_d   = cmd_q;
    dout_d  = dout_q;
`ifdef RTC_AUTO_WP_EN
    phase_d = phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          dir_d  = dir_rd;
          ram_d  = ram_sel;
          base_d = base;
          len_d  = len;
          idx_d  = '0;
          done_d = 1'b0;
          busy_d = 1'b1;
`ifdef RTC_AUTO_WP_EN
          phase_d = dir_rd ? PH_DATA : PH_PRE;
`endif
        end
      end
      S_ISSUE: begin
        if (ctl_idle) begin
          start_d = 1'b1;
          cmd_d   = {ram_q, addr, dir_q};
          dout_d  = dir_q ? 8'h00 : buf_mem[idx_q];
`ifdef RTC_AUTO_WP_EN
          if (phase_q == PH_PRE) begin
            cmd_d  = 7'h0E;
            dout_d = 8'h00;
          end else if (phase_q == PH_POST) begin
            cmd_d  = 7'h0E;
            dout_d = 8'h80;
          end
`endif
        end
      end
      S_NEXT: begin
        if (last_xfer) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
`ifdef RTC_AUTO_WP_EN
          if (phase_q == PH_PRE)     phase_d = PH_DATA;
          else if (idx_q == len_q)   phase_d = PH_POST;
          else                       idx_d   = idx_q + 1'b1;
`else
          idx_d = idx_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ioclr) begin
      dir_q   <= 1'b0;
      ram_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      cmd_q   <= '0;
      dout_q  <= '0;
`ifdef RTC_AUTO_WP_EN
      phase_q <= PH_DATA;
`endif
    end else begin
      dir_q   <= dir_d;
      ram_q   <= ram_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      cmd_q   <= cmd_d;
      dout_q  <= dout_d;
`ifdef RTC_AUTO_WP_EN
      phase_q <= phase_d;
`endif
    end
  end

  // Buffer has no reset so partial read results survive an abort.
  always_ff @(posedge clock) begin
    if (cap_we)                 buf_mem[idx_q]  <= ctl_din;
    else if (buf_we && !busy_q) buf_mem[buf_wa] <= buf_wd;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ctl_start = start_q;
  assign ctl_cmd   = cmd_q;
  assign ctl_dout  = dout_q;
  assign buf_rd    = buf_mem[buf_ra];

endmodule

// File: tb/tb_rtc_burst_seq.sv
// tb_rtc_burst_seq: directed bench for rtc_burst_seq with a behavioural rtc_control stub
// and a transaction-level scoreboard compared on every cycle.
`timescale 1ns/1ps
module tb_rtc_burst_seq;
  localparam int DEPTH  = 8;
  localparam int IW     = 3;
  localparam int STUB_N = 20;
`ifdef RTC_AUTO_WP_EN
  localparam bit WP_ON  = 1'b1;
  localparam int WP_OFS = 1;
`else
  localparam bit WP_ON  = 1'b0;
  localparam int WP_OFS = 0;
`endif

  logic          clock = 1'b0;
  logic          ioclr, go, dir_rd, ram_sel;
  logic [4:0]    base;
  logic [IW-1:0] len;
  logic          busy, done;
  logic          buf_we;
  logic [IW-1:0] buf_wa, buf_ra;
  logic [7:0]    buf_wd, buf_rd;
  logic [6:0]    ctl_cmd;
  logic [7:0]    ctl_dout;
  logic          ctl_start, ctl_idle;
  logic [7:0]    ctl_din;

  always #5 clock = ~clock;

  rtc_burst_seq #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ioclr(ioclr), .go(go), .dir_rd(dir_rd), .ram_sel(ram_sel),
    .base(base), .len(len), .busy(busy), .done(done),
    .buf_we(buf_we), .buf_wa(buf_wa), .buf_wd(buf_wd), .buf_ra(buf_ra), .buf_rd(buf_rd),
    .ctl_cmd(ctl_cmd), .ctl_dout(ctl_dout), .ctl_start(ctl_start),
    .ctl_idle(ctl_idle), .ctl_din(ctl_din)
  );

  // rtc_control stand-in: idle drops the cycle after start and returns STUB_N cycles later.
  int         stub_cnt = 0;
  logic       hold_low = 1'b0;
  logic [7:0] stub_din = 8'h00;
  assign ctl_idle = (stub_cnt == 0) && !hold_low;
  assign ctl_din  = stub_din;
  always @(posedge clock) begin
    if (ioclr) begin
      stub_cnt <= 0;
      stub_din <= 8'h00;
    end else if (ctl_start) begin
      stub_cnt <= STUB_N;
      stub_din <= 8'hA0 + {3'b000, ctl_cmd[5:1]};
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  mdl_buf [DEPTH];
  logic [14:0] exp_q [$];
  logic [6:0]  seen_cmd [$];
  logic [7:0]  seen_dout [$];
  int          n_starts = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected transaction list for one burst of n bytes, straight from the command format.
  function automatic void push_burst(input bit rd, input bit ram, input logic [4:0] b, input int n);
    logic [4:0] a;
    if (!rd && WP_ON) exp_q.push_back({7'h0E, 8'h00});
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(b) + i) % 32);
      exp_q.push_back({ram, a, rd, rd ? 8'h00 : mdl_buf[i]});
    end
    if (!rd && WP_ON) exp_q.push_back({7'h0E, 8'h80});
  endfunction

  function automatic void commit_read(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) mdl_buf[i] = 8'hA0 + 8'((int'(b) + i) % 32);
  endfunction

  // Per-cycle compare process.
  int          cyc = 0;
  int          last_rise = 0;
  logic        prev_start = 1'b0, prev_idle = 1'b1, prev_done = 1'b0, in_txn = 1'b0;
  logic [6:0]  held_cmd = '0;
  logic [7:0]  held_dout = '0;
  logic [14:0] exp_e;
  always @(negedge clock) begin
    cyc++;
    if (ctl_idle && !prev_idle) last_rise = cyc;
    if (ctl_start) begin
      checkOutput("start_not_back_to_back", 32'(prev_start), 32'd0);
      checkOutput("start_after_idle", 32'(prev_idle), 32'd1);
      checkOutput("start_while_busy", 32'(busy), 32'd1);
      checkOutput("start_expected", 32'(exp_q.size() != 0), 32'd1);
      n_starts++;
      seen_cmd.push_back(ctl_cmd);
      seen_dout.push_back(ctl_dout);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        checkOutput("txn_cmd", 32'(ctl_cmd), 32'(exp_e[14:8]));
        checkOutput("txn_dout", 32'(ctl_dout), 32'(exp_e[7:0]));
      end
      held_cmd  = ctl_cmd;
      held_dout = ctl_dout;
      in_txn    = 1'b1;
    end else if (in_txn) begin
      if (ctl_idle) in_txn = 1'b0;
      else begin
        checkOutput("cmd_hold", 32'(ctl_cmd), 32'(held_cmd));
        checkOutput("dout_hold", 32'(ctl_dout), 32'(held_dout));
      end
    end
    if (done && !prev_done) checkOutput("done_after_idle_rise", 32'(cyc - last_rise), 32'd2);
    prev_start = ctl_start;
    prev_idle  = ctl_idle;
    prev_done  = done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit rd, input bit ram, input logic [4:0] b, input int len_v);
    go      = 1'b1;
    dir_rd  = rd;
    ram_sel = ram;
    base    = b;
    len     = IW'(len_v);
    seen_cmd.delete();
    seen_dout.delete();
    n_starts = 0;
    push_burst(rd, ram, b, len_v + 1);
    tick();
    go = 1'b0;
  endtask

  task automatic hostWrite(input int idx, input logic [7:0] d);
    buf_we = 1'b1;
    buf_wa = IW'(idx);
    buf_wd = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int k = 0;
    while (!(done && !busy) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    checkOutput(name, {30'd0, done, busy}, 32'h2);
  endtask

  task automatic readBuf(input int idx, input string name, input logic [7:0] expected);
    tick();
    buf_ra = IW'(idx);
    @(negedge clock);
    checkOutput(name, 32'(buf_rd), 32'(expected));
  endtask

  task automatic checkBuffer(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      buf_ra = IW'(i);
      @(negedge clock);
      checkOutput($sformatf("%s_buf%0d", tag, i), 32'(buf_rd), 32'(mdl_buf[i]));
    end
  endtask

  initial begin
    ioclr = 1'b1; go = 1'b0; dir_rd = 1'b0; ram_sel = 1'b0; base = '0; len = '0;
    buf_we = 1'b0; buf_wa = '0; buf_wd = '0; buf_ra = '0;
    tick();
    tick();
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_start", 32'(ctl_start), 32'd0);
    checkOutput("rst_cmd", 32'(ctl_cmd), 32'd0);
    checkOutput("rst_dout", 32'(ctl_dout), 32'd0);
    tick();
    ioclr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hostWrite(i, 8'h00);
      mdl_buf[i] = 8'h00;
    end

    $display("[TB] read burst base 0 len 6");
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 6);
    @(negedge clock);
    checkOutput("t1_busy_latency", 32'(busy), 32'd1);
    checkOutput("t1_no_start_cycle1", 32'(ctl_start), 32'd0);
    waitDone("t1_done");
    commit_read(5'd0, 7);
    checkOutput("t1_starts", 32'(n_starts), 32'd7);
    checkOutput("t1_first_cmd", 32'(seen_cmd[0]), 32'h01);
    checkOutput("t1_last_cmd", 32'(seen_cmd[6]), 32'h0D);
    readBuf(3, "t1_buf3", 8'hA3);
    checkBuffer("t1");

    $display("[TB] write burst base 0 len 7");
    for (int i = 0; i < DEPTH; i++) begin
      hostWrite(i, 8'h11 + 8'(i));
      mdl_buf[i] = 8'h11 + 8'(i);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 7);
    waitDone("t2_done");
    checkOutput("t2_starts", 32'(n_starts), 32'(8 + 2 * WP_OFS));
    checkOutput("t2_first_data_cmd", 32'(seen_cmd[WP_OFS]), 32'h00);
    checkOutput("t2_first_data_dout", 32'(seen_dout[WP_OFS]), 32'h11);
    checkOutput("t2_last_data_cmd", 32'(seen_cmd[WP_OFS + 7]), 32'h0E);
    checkOutput("t2_last_data_dout", 32'(seen_dout[WP_OFS + 7]), 32'h18);
`ifdef RTC_AUTO_WP_EN
    checkOutput("t2_wp_clr_cmd", 32'(seen_cmd[0]), 32'h0E);
    checkOutput("t2_wp_clr_dout", 32'(seen_dout[0]), 32'h00);
    checkOutput("t2_wp_set_dout", 32'(seen_dout[9]), 32'h80);
`endif
    checkBuffer("t2");

    $display("[TB] go and host write in the same idle cycle");
    tick();
    buf_we = 1'b1; buf_wa = '0; buf_wd = 8'h77;
    mdl_buf[0] = 8'h77;
    applyStimulus(1'b0, 1'b0, 5'd5, 0);
    buf_we = 1'b0;
    waitDone("tc_done");
    checkOutput("tc_cmd", 32'(seen_cmd[WP_OFS]), 32'h0A);
    checkOutput("tc_dout", 32'(seen_dout[WP_OFS]), 32'h77);

    $display("[TB] wrapping RAM read base 31 len 1");
    tick();
    applyStimulus(1'b1, 1'b1, 5'd31, 1);
    waitDone("t3_done");
    commit_read(5'd31, 2);
    checkOutput("t3_cmd0", 32'(seen_cmd[0]), 32'h7F);
    checkOutput("t3_cmd1", 32'(seen_cmd[1]), 32'h41);
    readBuf(0, "t3_buf0", 8'hBF);
    readBuf(1, "t3_buf1", 8'hA0);

    $display("[TB] go and host write while busy");
    tick();
    applyStimulus(1'b0, 1'b0, 5'd16, 2);
    repeat (6) tick();
    go = 1'b1; dir_rd = 1'b1; base = 5'd3; len = 3'd5;
    buf_we = 1'b1; buf_wa = '0; buf_wd = 8'h55;
    tick();
    go = 1'b0; buf_we = 1'b0;
    @(negedge clock);
    checkOutput("t4_done_unchanged", 32'(done), 32'd0);
    checkOutput("t4_still_busy", 32'(busy), 32'd1);
    waitDone("t4_done");
    checkOutput("t4_starts", 32'(n_starts), 32'(3 + 2 * WP_OFS));
    repeat (40) tick();
    checkOutput("t4_no_extra_starts", 32'(n_starts), 32'(3 + 2 * WP_OFS));
    readBuf(0, "t4_buf0", 8'hBF);

    $display("[TB] ioclr during third transaction of a read");
    tick();
    hostWrite(2, 8'h5A);
    mdl_buf[2] = 8'h5A;
    applyStimulus(1'b1, 1'b0, 5'd0, 6);
    for (int k = 0; k < 500 && n_starts < 3; k++) @(negedge clock);
    checkOutput("t5_reach_third", 32'(n_starts >= 3), 32'd1);
    repeat (4) tick();
    ioclr = 1'b1;
    tick();
    ioclr = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_start", 32'(ctl_start), 32'd0);
    repeat (30) tick();
    checkOutput("t5_no_start_after_abort", 32'(n_starts), 32'd3);
    mdl_buf[0] = 8'hA0;
    mdl_buf[1] = 8'hA1;
    checkBuffer("t5");
    tick();
    applyStimulus(1'b1, 1'b0, 5'd4, 1);
    waitDone("t5_restart_done");
    commit_read(5'd4, 2);
    checkOutput("t5_restart_cmd", 32'(seen_cmd[0]), 32'h09);
    readBuf(0, "t5_restart_buf0", 8'hA4);

    $display("[TB] idle held low after go");
    tick();
    hold_low = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd10, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("t6_no_start_while_low", 32'(ctl_start), 32'd0);
    end
    tick();
    hold_low = 1'b0;
    waitDone("t6_done");
    commit_read(5'd10, 1);
    checkOutput("t6_starts", 32'(n_starts), 32'd1);
    checkOutput("t6_cmd", 32'(seen_cmd[0]), 32'h15);
    readBuf(0, "t6_buf0", 8'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
